// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable half-period divider, cpol idle level,
// pos/neg edge strobes for the shift register and bit counting with go/stop/done.
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 7
) (
  input  logic             wb_clk,
  input  logic             wb_reset,
  input  logic             go,
  input  logic             stop,
  input  logic             cpol,
  input  logic [DIV_W-1:0] divider,
  input  logic [CNT_W-1:0] char_len,
  output logic             sclk,
  output logic             pos_edge,
  output logic             neg_edge,
  output logic             lst_edge,
  output logic             tip,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W:0]   edge_cnt_q, edge_cnt_d;
  logic             sclk_q, sclk_d;
  logic             cpol_q, cpol_d;
  logic             done_q, done_d;

  logic             run;
  logic             tick;
  logic             strobe;
  logic             last;
  logic [CNT_W:0]   last_idx;

  always_ff @(posedge wb_clk) begin
    if (wb_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      len_q      <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      cpol_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      len_q      <= len_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      cpol_q     <= cpol_d;
      done_q     <= done_d;
    end
  end

  // len_q keeps the raw char_len; 0 wraps to all-ones here, i.e. 2*2**CNT_W-1
  assign last_idx = {len_q, 1'b0} - (CNT_W+1)'(1);

  assign run    = (state_q == RUN);
  assign tick   = run && (cnt_q == div_q);
  assign strobe = tick && !stop;
  assign last   = (edge_cnt_q == last_idx);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    len_d      = len_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    cpol_d     = cpol_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (go && !stop) begin
          state_d    = RUN;
          div_d      = divider;
          len_d      = char_len;
          cpol_d     = cpol;
          cnt_d      = '0;
          edge_cnt_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          sclk_d  = cpol;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = '0;
          if (last) begin
            state_d    = IDLE;
            sclk_d     = cpol_q;
            edge_cnt_d = '0;
            done_d     = 1'b1;
          end else begin
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_cnt_q + (CNT_W+1)'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sclk     = sclk_q;
  assign pos_edge = strobe && !sclk_q;
  assign neg_edge = strobe && sclk_q;
  assign lst_edge = strobe && last;
  assign tip      = run;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: cycle-exact vector table plus transfer scoreboard sequences.
module tb_spi_sclk_gen;

  logic        wb_clk;
  logic        wb_reset;
  logic        go;
  logic        stop;
  logic        cpol;
  logic [15:0] divider;
  logic [6:0]  char_len;
  logic        sclk;
  logic        pos_edge;
  logic        neg_edge;
  logic        lst_edge;
  logic        tip;
  logic        done;

  int checks;
  int errors;

  spi_sclk_gen #(.DIV_W(16), .CNT_W(7)) dut (
    .wb_clk   (wb_clk),
    .wb_reset (wb_reset),
    .go       (go),
    .stop     (stop),
    .cpol     (cpol),
    .divider  (divider),
    .char_len (char_len),
    .sclk     (sclk),
    .pos_edge (pos_edge),
    .neg_edge (neg_edge),
    .lst_edge (lst_edge),
    .tip      (tip),
    .done     (done)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  initial begin
    #1000000;
    $display("FAIL global timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  // exp = {sclk, pos_edge, neg_edge, lst_edge, tip, done}
  typedef struct packed {
    logic        go;
    logic        stop;
    logic        cpol;
    logic [15:0] div;
    logic [6:0]  len;
    logic [5:0]  exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic g, input logic s, input logic c,
                     input logic [15:0] d, input logic [6:0] l, input logic [5:0] e);
    vq.push_back({g, s, c, d, l, e});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Drive inputs 1 after the edge, leave outputs settled 2 after the edge.
  task automatic cyc(input logic g, input logic s, input logic c,
                     input logic [15:0] d, input logic [6:0] l);
    @(posedge wb_clk);
    #1;
    go = g; stop = s; cpol = c; divider = d; char_len = l;
    #1;
  endtask

  task automatic run_xfer(input logic c, input logic [15:0] d, input logic [6:0] l,
                          input bit mess, input string nm);
    int   len, exp_edges, bound, toggles, strobes, lsts, last_e;
    bit   finished, pp, pn;
    logic prev, g;
    len       = (l == 7'd0) ? 128 : int'(l);
    exp_edges = 2 * len;
    bound     = exp_edges * (int'(d) + 1) + 8;
    cyc(1'b0, 1'b0, c, d, l);
    cyc(1'b0, 1'b0, c, d, l);
    chk({nm, " idle sclk"}, {31'd0, sclk}, {31'd0, c});
    cyc(1'b1, 1'b0, c, d, l);
    prev = c; pp = 0; pn = 0; toggles = 0; strobes = 0; lsts = 0; last_e = 0; finished = 0;
    for (int k = 1; k <= bound && !finished; k++) begin
      if (mess) begin
        g = tip & ~lst_edge;
        cyc(g, 1'b0, c, 16'($urandom_range(0, 7)), 7'($urandom_range(1, 9)));
      end else begin
        cyc(1'b0, 1'b0, c, d, l);
      end
      if (pos_edge && neg_edge) chk({nm, " pos and neg together"}, 1, 0);
      if (pp) chk({nm, " rise after pos_edge"}, {30'd0, prev, sclk}, 32'd1);
      if (pn) chk({nm, " fall after neg_edge"}, {30'd0, prev, sclk}, 32'd2);
      if (sclk !== prev) begin
        toggles++;
        chk({nm, " half period"}, (k - 1) - last_e, int'(d) + 1);
        chk({nm, " toggle had strobe"}, {31'd0, pp | pn}, 1);
        last_e = k - 1;
      end
      if (pos_edge || neg_edge) strobes++;
      if (lst_edge) begin
        lsts++;
        chk({nm, " lst_edge position"}, strobes, exp_edges);
      end
      if (done) begin
        finished = 1;
        chk({nm, " done time"}, k - 1, exp_edges * (int'(d) + 1));
        chk({nm, " sclk at done"}, {31'd0, sclk}, {31'd0, c});
        chk({nm, " tip at done"}, {31'd0, tip}, 0);
      end
      pp = pos_edge; pn = neg_edge; prev = sclk;
    end
    chk({nm, " done seen"}, {31'd0, finished}, 1);
    chk({nm, " toggles"}, toggles, exp_edges);
    chk({nm, " strobes"}, strobes, exp_edges);
    chk({nm, " lst count"}, lsts, 1);
    cyc(1'b0, 1'b0, c, d, l);
    chk({nm, " done one cycle"}, {31'd0, done}, 0);
  endtask

  initial begin
    int   edges, k;
    logic prev;
    checks = 0; errors = 0;
    wb_reset = 1'b1; go = 1'b1; stop = 1'b0; cpol = 1'b1; divider = 16'd1; char_len = 7'd2;

    // reset values, even with cpol=1 and go=1 held
    repeat (2) @(posedge wb_clk);
    #2;
    chk("reset outputs", {26'd0, sclk, pos_edge, neg_edge, lst_edge, tip, done}, 0);
    @(posedge wb_clk);
    #1;
    wb_reset = 1'b0; go = 1'b0; cpol = 1'b0;
    #1;
    chk("reset released outputs", {26'd0, sclk, pos_edge, neg_edge, lst_edge, tip, done}, 0);

    // cpol=0 div=1 len=2; then cpol=1 div=0 len=3; then go+stop in IDLE
    add(1, 0, 0, 16'd1, 7'd2, 6'b000000);
    add(0, 0, 0, 16'd1, 7'd2, 6'b000010);
    add(0, 0, 0, 16'd1, 7'd2, 6'b010010);
    add(0, 0, 0, 16'd1, 7'd2, 6'b100010);
    add(0, 0, 0, 16'd1, 7'd2, 6'b101010);
    add(0, 0, 0, 16'd1, 7'd2, 6'b000010);
    add(0, 0, 0, 16'd1, 7'd2, 6'b010010);
    add(0, 0, 0, 16'd1, 7'd2, 6'b100010);
    add(0, 0, 0, 16'd1, 7'd2, 6'b101110);
    add(0, 0, 0, 16'd1, 7'd2, 6'b000001);
    add(0, 0, 1, 16'd0, 7'd3, 6'b000000);
    add(1, 0, 1, 16'd0, 7'd3, 6'b100000);
    add(0, 0, 1, 16'd0, 7'd3, 6'b101010);
    add(0, 0, 1, 16'd0, 7'd3, 6'b010010);
    add(0, 0, 1, 16'd0, 7'd3, 6'b101010);
    add(0, 0, 1, 16'd0, 7'd3, 6'b010010);
    add(0, 0, 1, 16'd0, 7'd3, 6'b101010);
    add(0, 0, 1, 16'd0, 7'd3, 6'b010110);
    add(0, 0, 1, 16'd0, 7'd3, 6'b100001);
    add(1, 1, 1, 16'd0, 7'd3, 6'b100000);
    add(0, 0, 1, 16'd0, 7'd3, 6'b100000);
    add(0, 0, 1, 16'd5, 7'd3, 6'b100000);
    for (int unsigned i = 0; i < vq.size(); i++) begin
      cyc(vq[i].go, vq[i].stop, vq[i].cpol, vq[i].div, vq[i].len);
      chk($sformatf("vec%0d", i), {26'd0, sclk, pos_edge, neg_edge, lst_edge, tip, done},
          {26'd0, vq[i].exp});
    end

    // stop after the 5th edge, in the cycle where neg_edge would fire
    cyc(0, 0, 0, 16'd3, 7'd8);
    cyc(0, 0, 0, 16'd3, 7'd8);
    cyc(1, 0, 0, 16'd3, 7'd8);
    edges = 0; k = 0; prev = 1'b0;
    while (edges < 5 && k < 100) begin
      cyc(0, 0, 0, 16'd3, 7'd8);
      if (sclk !== prev) edges++;
      prev = sclk;
      k++;
    end
    chk("stop reached 5 edges", edges, 5);
    cyc(0, 0, 0, 16'd3, 7'd8);
    cyc(0, 0, 0, 16'd3, 7'd8);
    cyc(0, 1, 0, 16'd3, 7'd8);
    chk("stop strobes suppressed", {30'd0, pos_edge, neg_edge}, 0);
    chk("stop cycle tip/sclk", {30'd0, tip, sclk}, 3);
    cyc(0, 0, 0, 16'd3, 7'd8);
    chk("after stop tip/sclk/done", {29'd0, tip, sclk, done}, 0);
    cyc(0, 0, 0, 16'd3, 7'd8);
    chk("after stop no done", {31'd0, done}, 0);
    run_xfer(1'b0, 16'd3, 7'd8, 1'b0, "restart");

    // go held and divider/char_len scrambled during RUN
    run_xfer(1'b0, 16'd2, 7'd5, 1'b1, "mid-run changes");

    // reset during RUN
    cyc(0, 0, 1, 16'd2, 7'd4);
    cyc(1, 0, 1, 16'd2, 7'd4);
    repeat (5) cyc(0, 0, 1, 16'd2, 7'd4);
    @(posedge wb_clk);
    #1 wb_reset = 1'b1;
    #1 chk("tip before reset", {31'd0, tip}, 1);
    @(posedge wb_clk);
    #1 wb_reset = 1'b0;
    #1 chk("reset mid-run", {26'd0, sclk, pos_edge, neg_edge, lst_edge, tip, done}, 0);
    cyc(0, 0, 1, 16'd2, 7'd4);
    chk("idle follows cpol", {30'd0, sclk, tip}, 2);

    run_xfer(1'b0, 16'd0, 7'd0, 1'b0, "char_len 0");
    run_xfer(1'b1, 16'd40, 7'd1, 1'b0, "long divider");

    for (int n = 0; n < 6; n++)
      run_xfer(1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)),
               7'($urandom_range(1, 6)), 1'b0, $sformatf("random%0d", n));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
